lfsr_share_arb: RTL and testbench

- Shares one 16-bit Galois LFSR random source among NUM_REQ requesters using round-robin arbitration.
- Sequences the source: default seed at reset, runtime reseed, warm-up stepping, and exactly one LFSR step per granted byte.
- Sits between the random-number consumers and the LFSR datapath, and owns both enable and seeding of the source.

---
 rtl/lfsr_share_arb_pkg.sv | 16 +
 rtl/lfsr16_galois.sv | 24 ++
 rtl/lfsr_share_arb.sv | 134 +++++++++++++
 tb/tb_lfsr_share_arb.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_share_arb_pkg.sv
// Shared definitions for the LFSR random-source arbiter.
//   LFSR_W / RAND_W : LFSR state width and width of the byte handed out per grant
//   LFSR_TAPS       : Galois feedback mask applied when the shifted-out bit is 1
//   state_t         : WARM (stepping, no grants) / RUN (arbitrating)
//   lfsr_step()     : one right-shift Galois step
package lfsr_share_arb_pkg;
  localparam int LFSR_W = 16;
  localparam int RAND_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {WARM = 1'b0, RUN = 1'b1} state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction
endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit Galois LFSR register.
//   clk, rst (async, active-low -> SEED_DEFAULT)
//   load/seed_in : load a new seed; a zero seed is replaced by SEED_DEFAULT so
//                  the register can never enter the all-zero lock-up state
//   step         : advance one Galois step (load has priority)
//   q            : current LFSR state
module lfsr16_galois
  import lfsr_share_arb_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         q <= SEED_DEFAULT;
    else if (load)    q <= (seed_in == '0) ? SEED_DEFAULT : seed_in;
    else if (step)    q <= lfsr_step(q);
  end
endmodule

// File: rtl/lfsr_share_arb.sv
// Round-robin arbiter sharing one 16-bit Galois LFSR among NUM_REQ requesters.
// Owns seeding and stepping of the source: default seed at reset, runtime
// reseed, WARMUP_CYC warm-up steps, then exactly one step per granted byte.
//   clk, rst       : clock, async active-low reset
//   req            : level requests, held until granted
//   seed_load      : one-cycle pulse, loads seed_in (zero -> SEED_DEFAULT)
//   gnt            : registered one-hot grant pulse
//   rand_out       : random byte, valid with rand_valid; holds otherwise
//   rand_valid     : high exactly when gnt is nonzero
//   busy           : high while warming up
//   grant_cnt      : per-requester 8-bit saturating grant counters, only when
//                    LFSR_SHARE_ARB_STATS_EN is defined
module lfsr_share_arb
  import lfsr_share_arb_pkg::*;
#(
  parameter int                NUM_REQ      = 4,
  parameter int                WARMUP_CYC   = 4,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               seed_load,
  input  logic [LFSR_W-1:0]  seed_in,
  output logic [NUM_REQ-1:0] gnt,
  output logic [RAND_W-1:0]  rand_out,
  output logic               rand_valid,
  output logic               busy
`ifdef LFSR_SHARE_ARB_STATS_EN
  ,
  output logic [NUM_REQ*8-1:0] grant_cnt
`endif
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(WARMUP_CYC + 1);

  state_t             state;
  logic [CNT_W-1:0]   warm_cnt;
  logic [PTR_W-1:0]   last;
  logic [LFSR_W-1:0]  lfsr;
  logic [NUM_REQ-1:0] elig, win_oh;
  logic [PTR_W-1:0]   win_idx;
  logic               win_vld;
  logic               arb_fire, lfsr_step_en;
  int                 idx;

  // Only the low byte is handed out; the upper bits just feed the LFSR.
  logic lfsr_hi_unused;
  assign lfsr_hi_unused = ^lfsr[LFSR_W-1:RAND_W];

  // Masking the current grant makes a held request yield for one cycle,
  // which also gives the requester time to drop req after its grant.
  // Loop runs farthest-first so the last write is the nearest to last+1.
  always_comb begin
    elig    = req & ~gnt;
    win_vld = 1'b0;
    win_idx = '0;
    win_oh  = '0;
    idx     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (elig[idx]) begin
        win_vld     = 1'b1;
        win_idx     = PTR_W'(idx);
        win_oh      = '0;
        win_oh[idx] = 1'b1;
      end
    end
  end

  // seed_load overrides any arbitration on the same edge.
  assign arb_fire     = (state == RUN) && win_vld && !seed_load;
  assign lfsr_step_en = ((state == WARM) && !seed_load) || arb_fire;
  assign busy         = (state == WARM);

  lfsr16_galois #(.SEED_DEFAULT(SEED_DEFAULT)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (seed_load),
    .seed_in (seed_in),
    .step    (lfsr_step_en),
    .q       (lfsr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= WARM;
      warm_cnt   <= '0;
      last       <= PTR_W'(NUM_REQ - 1);
      gnt        <= '0;
      rand_valid <= 1'b0;
      rand_out   <= '0;
    end else if (seed_load) begin
      state      <= WARM;
      warm_cnt   <= '0;
      gnt        <= '0;
      rand_valid <= 1'b0;
    end else if (state == WARM) begin
      gnt        <= '0;
      rand_valid <= 1'b0;
      if (warm_cnt == CNT_W'(WARMUP_CYC - 1)) begin
        state    <= RUN;
        warm_cnt <= '0;
      end else begin
        warm_cnt <= warm_cnt + 1'b1;
      end
    end else begin
      gnt        <= win_oh;
      rand_valid <= win_vld;
      if (win_vld) begin
        rand_out <= lfsr[RAND_W-1:0];  // pre-step value
        last     <= win_idx;
      end
    end
  end

`ifdef LFSR_SHARE_ARB_STATS_EN
  logic [NUM_REQ-1:0][7:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (seed_load) begin
      cnt <= '0;
    end else if (arb_fire) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (win_oh[i] && cnt[i] != 8'hFF) cnt[i] <= cnt[i] + 8'd1;
    end
  end

  assign grant_cnt = cnt;
`endif
endmodule

// File: tb/tb_lfsr_share_arb.sv
// Self-checking bench for lfsr_share_arb. Expected grants are pushed to a
// scoreboard as stimulus is driven; a negedge monitor pops and compares them.
module tb_lfsr_share_arb;
  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] g;
    logic [7:0]   r;
  } exp_t;

  logic         clk;
  logic         rst;
  logic [N-1:0] req;
  logic         seed_load;
  logic [15:0]  seed_in;
  logic [N-1:0] gnt;
  logic [7:0]   rand_out;
  logic         rand_valid;
  logic         busy;
`ifdef LFSR_SHARE_ARB_STATS_EN
  logic [N*8-1:0] grant_cnt;
`endif

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] m_lfsr;
  logic [7:0]  last_rand;
  bit          mon_en  = 0;

  lfsr_share_arb #(.NUM_REQ(N), .WARMUP_CYC(4), .SEED_DEFAULT(16'hACE1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .gnt        (gnt),
    .rand_out   (rand_out),
    .rand_valid (rand_valid),
    .busy       (busy)
`ifdef LFSR_SHARE_ARB_STATS_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] ref_step(input logic [15:0] s);
    logic [15:0] n;
    n = {1'b0, s[15:1]};
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic logic [15:0] ref_warm(input logic [15:0] seed);
    logic [15:0] s;
    s = (seed == 16'h0) ? 16'hACE1 : seed;
    for (int i = 0; i < 4; i++) s = ref_step(s);
    return s;
  endfunction

  task automatic expect_grant(input logic [N-1:0] g);
    exp_t e;
    e.g = g;
    e.r = m_lfsr[7:0];
    sb.push_back(e);
    m_lfsr = ref_step(m_lfsr);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected grants never seen, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Leaves the DUT one cycle into RUN with the default-seed warm-up done.
  task automatic do_reset;
    rst = 1'b0; req = '0; seed_load = 1'b0; seed_in = '0;
    last_rand = 8'h00;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) tick();
    m_lfsr = ref_warm(16'hACE1);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      n_tests++;
      if (rand_valid !== (gnt != '0)) begin
        n_fail++;
        $display("FAIL valid_vs_gnt: rand_valid=%b gnt=%b", rand_valid, gnt);
      end
      if (rand_valid === 1'b1) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_grant: gnt=%b rand_out=%h, no grant required", gnt, rand_out);
        end else begin
          e = sb.pop_front();
          if (gnt !== e.g || rand_out !== e.r) begin
            n_fail++;
            $display("FAIL grant: gnt=%b rand_out=%h, required gnt=%b rand_out=%h",
                     gnt, rand_out, e.g, e.r);
          end
        end
        last_rand = rand_out;
      end else begin
        n_tests++;
        if (rand_out !== last_rand) begin
          n_fail++;
          $display("FAIL rand_hold: rand_out=%h, required %h", rand_out, last_rand);
        end
      end
    end
  end

  task automatic test_reset;
    rst = 1'b0; req = '0; seed_load = 1'b0; seed_in = '0;
    last_rand = 8'h00;
    #2;
    mon_en = 1;
    n_tests++;
    if (busy !== 1'b1 || gnt !== '0 || rand_valid !== 1'b0 || rand_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b gnt=%b valid=%b rand=%h, required 1 0000 0 00",
               busy, gnt, rand_valid, rand_out);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL warm_busy[%0d]: busy=%b, required 1", i, busy);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (busy !== 1'b0 || gnt !== '0) begin
        n_fail++;
        $display("FAIL run_idle[%0d]: busy=%b gnt=%b, required 0 0000", i, busy, gnt);
      end
      tick();
    end
    check_drained("reset");
  endtask

  task automatic test_single;
    logic [7:0] lit [3];
    lit = '{8'h4E, 8'h27, 8'h13};
    do_reset();
    for (int k = 0; k < 3; k++) expect_grant(4'b0001);
    req = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_tests++;
      if (c % 2 == 0) begin
        if (gnt !== 4'b0001 || rand_out !== lit[c/2]) begin
          n_fail++;
          $display("FAIL single[%0d]: gnt=%b rand=%h, required 0001 %h", c, gnt, rand_out, lit[c/2]);
        end
      end else if (gnt !== 4'b0000) begin
        n_fail++;
        $display("FAIL single_gap[%0d]: gnt=%b, required 0000", c, gnt);
      end
    end
    req = '0;
    tick(); tick();
    check_drained("single");
  endtask

  task automatic test_all;
    logic [N-1:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int k = 0; k < 5; k++) expect_grant(order[k]);
    req = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_tests++;
      if (gnt !== order[c] || rand_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rr[%0d]: gnt=%b valid=%b, required %b 1", c, gnt, rand_valid, order[c]);
      end
    end
    req = '0;
    tick();
    n_tests++;
    if (rand_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_stop: rand_valid=%b, required 0", rand_valid);
    end
    tick();
    check_drained("all");
  endtask

  task automatic test_seed;
    do_reset();
    req = 4'b0001;
    expect_grant(4'b0001);
    tick();
    // zero seed on an edge where 0010 is eligible
    req = 4'b0010; seed_load = 1'b1; seed_in = 16'h0000;
    tick();
    seed_load = 1'b0;
    n_tests++;
    if (gnt !== '0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL seed0_edge: gnt=%b busy=%b, required 0000 1", gnt, busy);
    end
    m_lfsr = ref_warm(16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL seed0_busy[%0d]: busy=%b, required 1", i, busy);
      end
    end
    expect_grant(4'b0010);
    tick();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL seed0_run: busy=%b, required 0", busy);
    end
    tick();
    n_tests++;
    if (gnt !== 4'b0010 || rand_out !== 8'h4E) begin
      n_fail++;
      $display("FAIL seed0_grant: gnt=%b rand=%h, required 0010 4e", gnt, rand_out);
    end
    req = '0;
    // nonzero seed
    seed_load = 1'b1; seed_in = 16'h1234;
    tick();
    seed_load = 1'b0;
    m_lfsr = ref_warm(16'h1234);
    repeat (4) tick();
    req = 4'b0100;
    expect_grant(4'b0100);
    tick();
    n_tests++;
    if (gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL seed1234_grant: gnt=%b, required 0100", gnt);
    end
    req = '0;
    tick();
    check_drained("seed");
  endtask

  task automatic test_collide_reset;
    do_reset();
    // pointer is 3 -> 0001 would win; seed must win and leave the pointer alone
    req = 4'b0101; seed_load = 1'b1; seed_in = 16'hBEEF;
    tick();
    seed_load = 1'b0;
    n_tests++;
    if (gnt !== '0 || rand_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL collide: gnt=%b valid=%b busy=%b, required 0000 0 1", gnt, rand_valid, busy);
    end
    m_lfsr = ref_warm(16'hBEEF);
    repeat (4) tick();
    expect_grant(4'b0001);
    tick();
    n_tests++;
    if (gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL collide_ptr: gnt=%b, required 0001", gnt);
    end
    @(negedge clk); #1;
    rst = 1'b0;
    last_rand = 8'h00;
    #1;
    n_tests++;
    if (gnt !== '0 || rand_valid !== 1'b0 || rand_out !== 8'h00 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: gnt=%b valid=%b rand=%h busy=%b, required 0000 0 00 1",
               gnt, rand_valid, rand_out, busy);
    end
    req = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) tick();
    check_drained("collide_reset");
  endtask

`ifdef LFSR_SHARE_ARB_STATS_EN
  task automatic test_stats;
    do_reset();
    for (int k = 0; k < 300; k++) expect_grant(4'b0001);
    req = 4'b0001;
    repeat (10) tick();
    n_tests++;
    if (grant_cnt !== 32'h0000_0005) begin
      n_fail++;
      $display("FAIL stats_mid: grant_cnt=%h, required 00000005", grant_cnt);
    end
    repeat (590) tick();
    req = '0;
    n_tests++;
    if (grant_cnt !== 32'h0000_00FF) begin
      n_fail++;
      $display("FAIL stats_sat: grant_cnt=%h, required 000000ff", grant_cnt);
    end
    tick();
    check_drained("stats");
    seed_load = 1'b1; seed_in = 16'h5A5A;
    tick();
    seed_load = 1'b0;
    n_tests++;
    if (grant_cnt !== '0) begin
      n_fail++;
      $display("FAIL stats_clear: grant_cnt=%h, required 00000000", grant_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all();
    test_seed();
    test_collide_reset();
`ifdef LFSR_SHARE_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
